// File: rtl/crc16_pkg.sv
// Shared CRC-16 definitions (poly 0x1021, MSB-first, 16 bits per step) and the frame FSM encoding.
package crc16_pkg;

  localparam int          CRC16_W    = 16;
  localparam logic [15:0] CRC16_INIT = 16'h0000;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DATA     = 2'd1,
    EMIT_CRC = 2'd2
  } fsm_e;

  // Fold one 16-bit word into the CRC: xor in, then 16 shift/reduce steps.
  function automatic logic [CRC16_W-1:0] crc16_step(input logic [CRC16_W-1:0] crc,
                                                    input logic [CRC16_W-1:0] data);
    logic [CRC16_W-1:0] c;
    c = crc ^ data;
    for (int i = 0; i < CRC16_W; i++) begin
      c = c[CRC16_W-1] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc16_step.sv
// Combinational CRC-16 step: next CRC after folding one 16-bit data word into crc_i.
module crc16_step
  import crc16_pkg::*;
(
  input  logic [CRC16_W-1:0] crc_i,
  input  logic [CRC16_W-1:0] data_i,
  output logic [CRC16_W-1:0] crc_o
);

  assign crc_o = crc16_step(crc_i, data_i);

endmodule

// File: rtl/crc16_frame_appender.sv
// Forwards a framed 16-bit word stream unchanged and appends one CRC-16 word per frame.
// One output register, no skid buffer: in_ready drops whenever the held word is not taken.
module crc16_frame_appender
  import crc16_pkg::*;
#(
  parameter logic [15:0] CRC_INIT  = CRC16_INIT,
  parameter int          MAX_WORDS = 1024,
  parameter int          LEN_W     = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic             out_last,
  output logic             out_is_crc,
  output logic [LEN_W-1:0] frame_len,
  output logic             len_err
);

  localparam logic [LEN_W-1:0] MAX_CNT = LEN_W'(MAX_WORDS);

  fsm_e             state_q;
  logic [15:0]      crc_q;
  logic [15:0]      crc_d;
  logic [LEN_W-1:0] cnt_q;
  logic             out_valid_q;
  logic [15:0]      out_data_q;
  logic             out_last_q;
  logic             out_is_crc_q;
  logic [LEN_W-1:0] frame_len_q;
  logic             len_err_q;

  logic in_fire;
  logic out_fire;
  logic crc_loaded;

  // crc_q is back at CRC_INIT whenever the FSM sits in IDLE, so it seeds the first word too.
  crc16_step crc16_step_u (
    .crc_i  (crc_q),
    .data_i (in_data),
    .crc_o  (crc_d)
  );

  assign in_ready   = ~rst & (state_q != EMIT_CRC) & (~out_valid_q | out_ready);
  assign in_fire    = in_valid & in_ready;
  assign out_fire   = out_valid_q & out_ready;
  assign crc_loaded = out_valid_q & out_is_crc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      crc_q        <= CRC_INIT;
      cnt_q        <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      out_is_crc_q <= 1'b0;
      frame_len_q  <= '0;
      len_err_q    <= 1'b0;
    end else begin
      if (out_fire) begin
        out_valid_q <= 1'b0;
      end
      case (state_q)
        IDLE, DATA: begin
          if (in_fire) begin
            out_valid_q  <= 1'b1;
            out_data_q   <= in_data;
            out_last_q   <= 1'b0;
            out_is_crc_q <= 1'b0;
            crc_q        <= crc_d;
            if (state_q == IDLE) begin
              cnt_q <= LEN_W'(1);
            end else if (cnt_q >= MAX_CNT) begin
              len_err_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + LEN_W'(1);
            end
            state_q <= in_last ? EMIT_CRC : DATA;
          end
        end
        EMIT_CRC: begin
          if (crc_loaded) begin
            if (out_fire) begin
              out_last_q   <= 1'b0;
              out_is_crc_q <= 1'b0;
              crc_q        <= CRC_INIT;
              cnt_q        <= '0;
              state_q      <= IDLE;
            end
          end else if (~out_valid_q | out_fire) begin
            out_valid_q  <= 1'b1;
            out_data_q   <= crc_q;
            out_last_q   <= 1'b1;
            out_is_crc_q <= 1'b1;
            frame_len_q  <= cnt_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_last   = out_last_q;
  assign out_is_crc = out_is_crc_q;
  assign frame_len  = frame_len_q;
  assign len_err    = len_err_q;

endmodule

// File: tb/tb_crc16_frame_appender.sv
// Directed bench for crc16_frame_appender with MAX_WORDS=4 so the overlength path is reachable.
module tb_crc16_frame_appender;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_last;
  logic        out_is_crc;
  logic [10:0] frame_len;
  logic        len_err;

  int checks = 0;
  int errors = 0;

  // Accepted output words as {is_crc, last, data}.
  logic [17:0] outq[$];

  crc16_frame_appender #(
    .CRC_INIT  (16'h0000),
    .MAX_WORDS (4),
    .LEN_W     (11)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .out_is_crc (out_is_crc),
    .frame_len  (frame_len),
    .len_err    (len_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs only change just after posedge, so a handshake seen here completes on the next edge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) outq.push_back({out_is_crc, out_last, out_data});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [15:0] d, input logic l);
    int k;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) chk("send_timeout", 32'(k), 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_outputs(input int n, input string tag);
    int k;
    k = 0;
    while (outq.size() < n && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    @(posedge clk);
    #1;
    chk(tag, 32'(outq.size()), 32'(n));
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 16'h0000;
    in_last   = 1'b0;
    out_ready = 1'b1;

    // Reset state
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_flags", {30'd0, out_last, out_is_crc}, 32'd0);
    chk("rst_frame_len", 32'(frame_len), 32'd0);
    chk("rst_len_err", 32'(len_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_in_ready", 32'(in_ready), 32'd1);

    // Two-word frame
    send(16'h0001, 1'b0);
    send(16'h0000, 1'b1);
    wait_outputs(3, "A_count");
    chk("A_w0", 32'(outq[0]), {14'd0, 18'h00001});
    chk("A_w1", 32'(outq[1]), {14'd0, 18'h00000});
    chk("A_crc", 32'(outq[2]), {14'd0, 2'b11, 16'h3730});
    chk("A_frame_len", 32'(frame_len), 32'd2);
    chk("A_len_err", 32'(len_err), 32'd0);
    outq.delete();

    // Single-word frame
    send(16'hFFFF, 1'b1);
    wait_outputs(2, "B_count");
    chk("B_w0", 32'(outq[0]), {14'd0, 18'h0FFFF});
    chk("B_crc", 32'(outq[1]), {14'd0, 2'b11, 16'h1D0F});
    chk("B_frame_len", 32'(frame_len), 32'd1);
    outq.delete();

    // Downstream stall with out_ready 1,0,0,1 around the CRC word
    out_ready = 1'b0;
    send(16'h0001, 1'b1);
    chk("C_lat_valid", 32'(out_valid), 32'd1);
    chk("C_lat_data", 32'(out_data), 32'h0001);
    chk("C_in_ready_emit", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'hABCD;
    for (int i = 0; i < 2; i++) begin
      chk("C_stall_valid", 32'(out_valid), 32'd1);
      chk("C_stall_data", 32'(out_data), 32'h1021);
      chk("C_stall_flags", {30'd0, out_last, out_is_crc}, 32'd3);
      chk("C_stall_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_outputs(2, "C_count");
    chk("C_w0", 32'(outq[0]), {14'd0, 18'h00001});
    chk("C_crc", 32'(outq[1]), {14'd0, 2'b11, 16'h1021});
    outq.delete();

    // Back-to-back single-word frames: seed must reload in between
    send(16'h0001, 1'b1);
    send(16'h0000, 1'b1);
    wait_outputs(4, "D_count");
    chk("D_crc0", 32'(outq[1]), {14'd0, 2'b11, 16'h1021});
    chk("D_w1", 32'(outq[2]), {14'd0, 18'h00000});
    chk("D_crc1", 32'(outq[3]), {14'd0, 2'b11, 16'h0000});
    outq.delete();

    // Reset in the middle of a frame
    send(16'h0011, 1'b0);
    send(16'h0022, 1'b0);
    send(16'h0033, 1'b0);
    rst = 1'b1;
    #2;
    chk("E_rst_out_valid", 32'(out_valid), 32'd0);
    chk("E_rst_frame_len", 32'(frame_len), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    outq.delete();
    @(posedge clk);
    #1;
    send(16'hFFFF, 1'b1);
    wait_outputs(2, "E_count");
    repeat (4) @(posedge clk);
    #1;
    chk("E_no_extra", 32'(outq.size()), 32'd2);
    chk("E_w0", 32'(outq[0]), {14'd0, 18'h0FFFF});
    chk("E_crc", 32'(outq[1]), {14'd0, 2'b11, 16'h1D0F});
    outq.delete();

    // Overlength frame: 6 words against MAX_WORDS=4
    for (int i = 0; i < 5; i++) send(16'h0000, 1'b0);
    send(16'h0001, 1'b1);
    wait_outputs(7, "F_count");
    chk("F_w4", 32'(outq[4]), {14'd0, 18'h00000});
    chk("F_w5", 32'(outq[5]), {14'd0, 18'h00001});
    chk("F_crc", 32'(outq[6]), {14'd0, 2'b11, 16'h1021});
    chk("F_len_err", 32'(len_err), 32'd1);
    chk("F_frame_len", 32'(frame_len), 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
